i2c_config_sequencer: RTL
=========================

// Module: i2c_config_sequencer
// PURPOSE
//  Upstream driver for the i2cInterface write engine. Walks a table of {register address, register data}
//  pairs (the HDMI transmitter init list) held in an external synchronous ROM. For each entry it presents
//  slave/register address and data, pulses i2cStart, and waits for completion. It retries failed writes
//  and reports overall done/error to the top level.
// PARAMETERS
//  SLAVE_ADDR     8'h72   7-bit device address in [7:1]; [0] is forced to 0 (write)
//  NUM_REGS       32      table entries to issue (1..2**IDX_W)
//  IDX_W          6       width of tableIndex / failIndex
//  POWERUP_WAIT   20'd1000 clockIn cycles to wait after reset before the first write (>=1)
//  START_CYCLES   4       cycles i2cStart is held high per transaction (>=1)
//  TIMEOUT_CYCLES 16'd2000 max cycles from i2cStart falling to i2cDone before the attempt fails
//  RETRY_LIMIT    3       attempts per entry (>=1) before declaring error
// PORTS
//  clockIn        in   1      system clock (also the i2cInterface clock)
//  reset_n        in   1      asynchronous active-low reset
//  configRestart  in   1      1-cycle pulse; honoured only in DONE or ERROR; restarts from entry 0, no power-up wait
//  tableIndex     out  IDX_W  ROM read address
//  tableData      in   16     ROM data {regAddr[15:8], regData[7:0]}, valid 1 cycle after tableIndex changes
//  slaveAddress   out  8      {SLAVE_ADDR[7:1],1'b0}, held stable for the whole transaction
//  dataAddress    out  8      register address of the current entry
//  data           out  8      register data of the current entry
//  i2cStart       out  1      start strobe to i2cInterface
//  i2cDone        in   1      1-cycle pulse: transaction finished
//  i2cAckError    in   1      sampled with i2cDone; 1 = NACK seen
//  configBusy     out  1      1 in every state except DONE/ERROR
//  configDone     out  1      1 while in DONE
//  configError    out  1      1 while in ERROR
//  failIndex      out  IDX_W  index of the entry that exhausted its retries; valid while configError=1
// BEHAVIOUR
//  Reset (async assert, sync release): state=PWR_WAIT, all counters and index=0, i2cStart=0,
//   dataAddress=data=0, configBusy=1, configDone=configError=0, failIndex=0.
//   slaveAddress is constant {SLAVE_ADDR[7:1],0}.
//  States:
//   PWR_WAIT  count POWERUP_WAIT cycles -> FETCH.
//   FETCH     drive tableIndex=index; 1 cycle -> LATCH (ROM latency).
//   LATCH     capture tableData into dataAddress/data; retryCnt=0.
//             If tableData==16'hFFFF (sentinel) -> DONE; otherwise -> START_HI.
//   START_HI  i2cStart=1 for exactly START_CYCLES cycles -> START_LO.
//   START_LO  i2cStart=0; timeout counter cleared -> WAIT_DONE next cycle.
//   WAIT_DONE i2cDone & !i2cAckError -> NEXT.
//             (i2cDone & i2cAckError) or timeout reached -> RETRY.
//             i2cDone pulses outside WAIT_DONE are ignored.
//   RETRY     retryCnt+1; if retryCnt+1 < RETRY_LIMIT -> START_HI (same entry, outputs unchanged);
//             else failIndex=index -> ERROR.
//   NEXT      if index==NUM_REGS-1 -> DONE; else index+1 -> FETCH.
//   DONE/ERROR terminal; configRestart -> index=0, flags cleared -> FETCH.
//  dataAddress/data change only in LATCH, never while i2cStart=1 or in WAIT_DONE.
//  Exactly one i2cStart high period per attempt; no back-to-back starts without a START_LO cycle.
//  index never exceeds NUM_REGS-1 (no wrap). Counters saturate and do not wrap.
//  configRestart in any other state is ignored.
//  reset_n low mid-transaction: i2cStart drops immediately (async); the sequence restarts at PWR_WAIT.
// TESTING
//  1. NUM_REGS=3, ROM {0x4110,0x9803,0xD6C0}, model acks all -> 3 starts, addr/data pairs in order,
//     configDone=1, configError=0.
//  2. Entry 1 NACKed once, then acked -> 4 starts total, entry 1 repeated with identical data, configDone=1.
//  3. Entry 2 NACKed on every attempt, RETRY_LIMIT=3 -> 3 starts on entry 2, configError=1, failIndex=2,
//     no further starts.
//  4. Model never asserts i2cDone -> fail after TIMEOUT_CYCLES per attempt, RETRY_LIMIT attempts,
//     configError=1, failIndex=0.
//  5. ROM entry 1 = 16'hFFFF -> only entry 0 written, configDone=1, tableIndex stays 1.
//  6. Assert reset_n low while i2cStart=1, then in DONE pulse configRestart -> i2cStart=0 at once;
//     the sequence reruns after POWERUP_WAIT; restart skips the power-up wait and begins at entry 0.

Source files
------------

// File: rtl/i2c_config_sequencer_if.sv
// Write-request channel between the config sequencer (master) and the i2cInterface write engine (slave).
interface i2c_config_sequencer_if;
  logic [7:0] slaveAddress;
  logic [7:0] dataAddress;
  logic [7:0] data;
  logic       i2cStart;
  logic       i2cDone;
  logic       i2cAckError;

  modport master (
    output slaveAddress, dataAddress, data, i2cStart,
    input  i2cDone, i2cAckError
  );

  modport slave (
    input  slaveAddress, dataAddress, data, i2cStart,
    output i2cDone, i2cAckError
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks a ROM table of {regAddr, regData} pairs and issues one I2C register write per entry,
// retrying failed or timed-out writes and reporting overall done/error.
module i2c_config_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h72,
  parameter int          NUM_REGS       = 32,
  parameter int          IDX_W          = 6,
  parameter logic [19:0] POWERUP_WAIT   = 20'd1000,
  parameter int          START_CYCLES   = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000,
  parameter int          RETRY_LIMIT    = 3
) (
  input  logic                   clockIn,
  input  logic                   reset_n,
  input  logic                   configRestart,
  output logic [IDX_W-1:0]       tableIndex,
  input  logic [15:0]            tableData,
  i2c_config_sequencer_if.master i2c,
  output logic                   configBusy,
  output logic                   configDone,
  output logic                   configError,
  output logic [IDX_W-1:0]       failIndex
);

  typedef enum logic [3:0] {
    PWR_WAIT,
    FETCH,
    LATCH,
    START_HI,
    START_LO,
    WAIT_DONE,
    RETRY,
    NEXT,
    DONE,
    ERROR
  } stateType;

  localparam int START_W = $clog2(START_CYCLES + 1);
  localparam int RETRY_W = $clog2(RETRY_LIMIT + 1);

  localparam logic [START_W-1:0] START_LAST   = START_W'(START_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(RETRY_LIMIT - 1);
  localparam logic [IDX_W-1:0]   INDEX_LAST   = IDX_W'(NUM_REGS - 1);
  localparam logic [19:0]        PWR_LAST     = POWERUP_WAIT - 20'd1;
  localparam logic [15:0]        TIMEOUT_LAST = TIMEOUT_CYCLES - 16'd1;
  localparam logic [15:0]        SENTINEL     = 16'hFFFF;

  stateType           state;
  stateType           nextState;
  logic [IDX_W-1:0]   index;
  logic [19:0]        pwrCnt;
  logic [START_W-1:0] startCnt;
  logic [15:0]        timeoutCnt;
  logic [RETRY_W-1:0] retryCnt;
  logic [7:0]         regAddr;
  logic [7:0]         regData;

  // NOTE: asynchronous reset puts the FSM straight into PWR_WAIT, so i2cStart
  // (decoded from state) drops the instant reset_n falls, without waiting for a clock.
  always_ff @(posedge clockIn or negedge reset_n) begin
    if (!reset_n) begin
      state <= PWR_WAIT;
    end else begin
      // NOTE: non-blocking assignment for every registered signal, so all
      // flops update together from values sampled before the edge.
      state <= nextState;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns nextState and no latch is inferred.
    nextState = state;
    case (state)
      PWR_WAIT:  if (pwrCnt >= PWR_LAST) nextState = FETCH;
      FETCH:     nextState = LATCH;
      LATCH:     nextState = (tableData == SENTINEL) ? DONE : START_HI;
      START_HI:  if (startCnt >= START_LAST) nextState = START_LO;
      START_LO:  nextState = WAIT_DONE;
      WAIT_DONE: begin
        if (i2c.i2cDone && !i2c.i2cAckError) begin
          nextState = NEXT;
        end else if (i2c.i2cDone || (timeoutCnt >= TIMEOUT_LAST)) begin
          nextState = RETRY;
        end
      end
      RETRY:     nextState = (retryCnt < RETRY_LAST) ? START_HI : ERROR;
      NEXT:      nextState = (index == INDEX_LAST) ? DONE : FETCH;
      DONE,
      ERROR:     if (configRestart) nextState = FETCH;
      default:   nextState = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clockIn or negedge reset_n) begin
    if (!reset_n) begin
      index      <= '0;
      pwrCnt     <= '0;
      startCnt   <= '0;
      timeoutCnt <= '0;
      retryCnt   <= '0;
      regAddr    <= '0;
      regData    <= '0;
      failIndex  <= '0;
    end else begin
      if ((state == PWR_WAIT) && (pwrCnt < PWR_LAST)) begin
        pwrCnt <= pwrCnt + 20'd1;
      end

      if (state == START_HI) begin
        if (startCnt < START_LAST) startCnt <= startCnt + 1'b1;
      end else begin
        startCnt <= '0;
      end

      // Counts cycles since i2cStart fell; cleared everywhere outside WAIT_DONE, including START_LO.
      if (state == WAIT_DONE) begin
        if (timeoutCnt < TIMEOUT_LAST) timeoutCnt <= timeoutCnt + 16'd1;
      end else begin
        timeoutCnt <= '0;
      end

      case (state)
        LATCH: begin
          regAddr  <= tableData[15:8];
          regData  <= tableData[7:0];
          retryCnt <= '0;
        end
        RETRY: begin
          if (retryCnt < RETRY_LAST) begin
            retryCnt <= retryCnt + 1'b1;
          end else begin
            failIndex <= index;
          end
        end
        NEXT: begin
          if (index != INDEX_LAST) index <= index + 1'b1;
        end
        DONE, ERROR: begin
          if (configRestart) begin
            index     <= '0;
            failIndex <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tableIndex       = index;
  assign i2c.slaveAddress = {SLAVE_ADDR[7:1], 1'b0};
  assign i2c.dataAddress  = regAddr;
  assign i2c.data         = regData;
  assign i2c.i2cStart     = (state == START_HI);
  assign configBusy       = (state != DONE) && (state != ERROR);
  assign configDone       = (state == DONE);
  assign configError      = (state == ERROR);

endmodule
